// File: rtl/accum_stage_pkg.sv
// ---------------------------------------------------------------------------
// accum_stage_pkg
// Shared definitions for the accumulation stage:
//   - default datapath width (N_DEF) and operand-count width (LEN_W_DEF)
//   - FSM state enumeration (IDLE / ACCUM / DONE)
//   - saturation bounds MAX_POS / MAX_NEG at the default width; the top
//     scales them to N by keeping the sign bit and filling the rest.
// ---------------------------------------------------------------------------
package accum_stage_pkg;

  localparam int N_DEF     = 32;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [31:0] MAX_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] MAX_NEG = 32'h8000_0000;

endpackage : accum_stage_pkg

// File: rtl/accum_stage_csa.sv
// ---------------------------------------------------------------------------
// carry_select_adder
// N-bit adder built from 4-bit carry-select blocks. Each block precomputes
// its nibble sum for carry-in 0 and 1; the incoming block carry picks one.
// Ports:
//   a_i, b_i  [N-1:0]  addends
//   cin_i              carry-in
//   sum_o     [N-1:0]  sum (mod 2^N)
//   cout_o             carry-out of the top bit
// N must be a multiple of 4.
// ---------------------------------------------------------------------------
module carry_select_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  localparam int NB = N / 4;

  logic [NB:0] c_s;

  assign c_s[0] = cin_i;

  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [4:0] s0_s;
    logic [4:0] s1_s;

    // Both candidate nibble sums; s1 never exceeds 5'd31, so no wrap.
    assign s0_s = {1'b0, a_i[4*g +: 4]} + {1'b0, b_i[4*g +: 4]};
    assign s1_s = s0_s + 5'd1;

    assign sum_o[4*g +: 4] = c_s[g] ? s1_s[3:0] : s0_s[3:0];
    assign c_s[g+1]        = c_s[g] ? s1_s[4]   : s0_s[4];
  end

  assign cout_o = c_s[NB];

endmodule : carry_select_adder

// File: rtl/accum_stage.sv
// ---------------------------------------------------------------------------
// accum_stage
// Accumulates len_i signed operands over a valid/ready stream and presents
// the sum plus sticky signed-overflow and unsigned-carry flags on a
// valid/ready result port.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_i, len_i             request + operand count (taken in IDLE only)
//   busy_o                     high in ACCUM or DONE
//   op_valid_i/op_ready_o      operand handshake, op_data_i [N-1:0]
//   res_valid_o/res_ready_i    result handshake
//   res_sum_o [N-1:0]          accumulator register
//   res_of_o, res_carry_o      sticky flags for the current accumulation
// Configuration macro:
//   ACCUM_STAGE_SAT_EN  - overflowing steps clamp to the signed max/min
//                         instead of wrapping (res_of_o still sets).
// ---------------------------------------------------------------------------
module accum_stage
  import accum_stage_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [N-1:0]     op_data_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [N-1:0]     res_sum_o,
  output logic             res_of_o,
  output logic             res_carry_o
);

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             of_q, of_d;
  logic             carry_q, carry_d;

  logic [N-1:0]     add_sum_s;
  logic             add_cout_s;
  logic             ovf_s;
  logic [N-1:0]     acc_next_s;

  carry_select_adder #(
    .N (N)
  ) u_adder (
    .a_i    (acc_q),
    .b_i    (op_data_i),
    .cin_i  (1'b0),
    .sum_o  (add_sum_s),
    .cout_o (add_cout_s)
  );

  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf_s = (acc_q[N-1] == op_data_i[N-1]) && (add_sum_s[N-1] != acc_q[N-1]);

`ifdef ACCUM_STAGE_SAT_EN
  localparam logic [N-1:0] SAT_POS = {MAX_POS[31], {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_NEG = {MAX_NEG[31], {(N-1){1'b0}}};

  // Clamp toward the sign both operands share when the step overflows.
  always_comb begin
    acc_next_s = add_sum_s;
    if (ovf_s) begin
      acc_next_s = acc_q[N-1] ? SAT_NEG : SAT_POS;
    end else begin
      acc_next_s = add_sum_s;
    end
  end
`else
  // Wrapping accumulation: the raw adder sum is always taken.
  always_comb begin
    acc_next_s = add_sum_s;
  end
`endif

  // Next-state and datapath update for IDLE / ACCUM / DONE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    of_d    = of_q;
    carry_d = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          acc_d   = '0;
          of_d    = 1'b0;
          carry_d = 1'b0;
          cnt_d   = len_i;
          state_d = (len_i == '0) ? ST_DONE : ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (op_valid_i) begin
          acc_d   = acc_next_s;
          of_d    = of_q | ovf_s;
          carry_d = carry_q | add_cout_s;
          cnt_d   = cnt_q - CNT_ONE;
          state_d = (cnt_q == CNT_ONE) ? ST_DONE : ST_ACCUM;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (res_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      of_q    <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      of_q    <= of_d;
      carry_q <= carry_d;
    end
  end

  // Handshake outputs decode the state register only.
  assign op_ready_o  = (state_q == ST_ACCUM);
  assign res_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign res_sum_o   = acc_q;
  assign res_of_o    = of_q;
  assign res_carry_o = carry_q;

endmodule : accum_stage

// File: tb/tb_accum_stage.sv
// ---------------------------------------------------------------------------
// tb_accum_stage
// Directed self-checking bench for accum_stage (N=32, LEN_W=8).
// Inputs change and outputs are sampled on the falling clock edge.
// stat = {busy, op_ready, res_valid, res_of, res_carry}
// ---------------------------------------------------------------------------
module tb_accum_stage;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_data;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_sum;
  logic        res_of;
  logic        res_carry;
  logic [4:0]  stat;

  int n_checks = 0;
  int n_fail   = 0;

  accum_stage #(.N(32), .LEN_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .len_i       (len),
    .busy_o      (busy),
    .op_valid_i  (op_valid),
    .op_ready_o  (op_ready),
    .op_data_i   (op_data),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_sum_o   (res_sum),
    .res_of_o    (res_of),
    .res_carry_o (res_carry)
  );

  assign stat = {busy, op_ready, res_valid, res_of, res_carry};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len = 8'd0; op_valid = 1'b0;
    op_data = 32'd0; res_ready = 1'b0;
    #2;
    n_checks++;
    if (stat !== 5'b00000 || res_sum !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: stat=%b sum=%h expected stat=00000 sum=00000000", stat, res_sum);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    start = 1'b1; len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (stat !== 5'b11000) begin
      n_fail++;
      $display("FAIL basic_accum_state: stat=%b expected 11000", stat);
    end
    op_valid = 1'b1; op_data = 32'd5;
    @(negedge clk); op_data = 32'd7;
    @(negedge clk); op_data = 32'hFFFF_FFFE;
    @(negedge clk); op_valid = 1'b0;
    n_checks++;
    if (stat !== 5'b10101 || res_sum !== 32'd10) begin
      n_fail++;
      $display("FAIL basic_result: stat=%b sum=%h expected stat=10101 sum=0000000a", stat, res_sum);
    end
    res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
    n_checks++;
    if (stat[4:2] !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_back_to_idle: stat=%b expected 000xx", stat);
    end
  endtask

  task automatic test_len_zero();
    start = 1'b1; len = 8'd0;
    @(negedge clk);
    // Extra start and stray operands while in DONE must be ignored.
    start = 1'b1; len = 8'd3; op_valid = 1'b1; op_data = 32'd123;
    n_checks++;
    if (stat !== 5'b10100 || res_sum !== 32'd0) begin
      n_fail++;
      $display("FAIL len0_result: stat=%b sum=%h expected stat=10100 sum=00000000", stat, res_sum);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (stat !== 5'b10100 || res_sum !== 32'd0) begin
        n_fail++;
        $display("FAIL len0_hold[%0d]: stat=%b sum=%h expected stat=10100 sum=00000000", i, stat, res_sum);
      end
    end
    start = 1'b0; op_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
    n_checks++;
    if (stat !== 5'b00000) begin
      n_fail++;
      $display("FAIL len0_release: stat=%b expected 00000", stat);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] a_v [2];
    logic [31:0] b_v [2];
    logic [31:0] exp_v [2];
    logic [4:0]  st_v [2];
    a_v[0] = 32'h7FFF_FFFF; b_v[0] = 32'h0000_0001; st_v[0] = 5'b10110;
    a_v[1] = 32'h8000_0000; b_v[1] = 32'hFFFF_FFFF; st_v[1] = 5'b10111;
`ifdef ACCUM_STAGE_SAT_EN
    exp_v[0] = 32'h7FFF_FFFF; exp_v[1] = 32'h8000_0000;
`else
    exp_v[0] = 32'h8000_0000; exp_v[1] = 32'h7FFF_FFFF;
`endif
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; len = 8'd2;
      @(negedge clk); start = 1'b0; op_valid = 1'b1; op_data = a_v[k];
      @(negedge clk); op_data = b_v[k];
      @(negedge clk); op_valid = 1'b0;
      n_checks++;
      if (stat !== st_v[k] || res_sum !== exp_v[k]) begin
        n_fail++;
        $display("FAIL overflow[%0d]: stat=%b sum=%h expected stat=%b sum=%h", k, stat, res_sum, st_v[k], exp_v[k]);
      end
      res_ready = 1'b1;
      @(negedge clk); res_ready = 1'b0;
    end
  endtask

  task automatic test_gapped();
    logic        vld_v [7];
    logic [31:0] dat_v [7];
    vld_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    dat_v = '{32'd100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFCE,
              32'd20, 32'hDEAD_BEEF, 32'd3};
    start = 1'b1; len = 8'd4;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (stat[4:2] !== 3'b110) begin
        n_fail++;
        $display("FAIL gapped_accum[%0d]: stat=%b expected 110xx", i, stat);
      end
      start    = (i == 1);
      len      = 8'd7;
      op_valid = vld_v[i];
      op_data  = dat_v[i];
      @(negedge clk);
    end
    start = 1'b0; op_valid = 1'b0;
    n_checks++;
    if (stat !== 5'b10101 || res_sum !== 32'd73) begin
      n_fail++;
      $display("FAIL gapped_result: stat=%b sum=%h expected stat=10101 sum=00000049", stat, res_sum);
    end
    op_valid = 1'b1; op_data = 32'd5; start = 1'b1;
    @(negedge clk); op_valid = 1'b0; start = 1'b0;
    n_checks++;
    if (stat !== 5'b10101 || res_sum !== 32'd73) begin
      n_fail++;
      $display("FAIL gapped_done_hold: stat=%b sum=%h expected stat=10101 sum=00000049", stat, res_sum);
    end
    res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; len = 8'd5;
    @(negedge clk); start = 1'b0; op_valid = 1'b1; op_data = 32'd11;
    @(negedge clk); op_data = 32'd22;
    @(negedge clk); op_data = 32'd33;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (stat !== 5'b00000 || res_sum !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_accum: stat=%b sum=%h expected stat=00000 sum=00000000", stat, res_sum);
    end
    @(negedge clk);
    rst_n = 1'b1; op_valid = 1'b0; start = 1'b1; len = 8'd1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if (stat !== 5'b11000 || res_sum !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_first_start: stat=%b sum=%h expected stat=11000 sum=00000000", stat, res_sum);
    end
    op_valid = 1'b1; op_data = 32'd9;
    @(negedge clk); op_valid = 1'b0;
    n_checks++;
    if (stat !== 5'b10100 || res_sum !== 32'd9) begin
      n_fail++;
      $display("FAIL reset_new_result: stat=%b sum=%h expected stat=10100 sum=00000009", stat, res_sum);
    end
    // Reset while a result is waiting in DONE.
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (stat !== 5'b00000 || res_sum !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_done: stat=%b sum=%h expected stat=00000 sum=00000000", stat, res_sum);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_overflow();
    test_gapped();
    test_reset_mid();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_accum_stage
